ppg_frontend_emulator: RTL and testbench
========================================

# ppg_frontend_emulator

Synthesizable model of the photoplethysmography analog front end: photodiode, DC compensation DAC, PGA and 8-bit ADC. It is the responder on the controller's LED/DC_Comp/PGA_Gain drive interface and returns the `ADC` sample the controller calibrates and operates against. It is used in FPGA bring-up and closed-loop simulation so the controller's find-setting sequence converges on deterministic, known-answer data.

## Interface
- `RED_DC`, 200, red baseline photocurrent code at `LED_DRIVE`=8 (8-bit)
- `IR_DC`, 180, IR baseline code at `LED_DRIVE`=8 (8-bit)
- `RED_AC`, 8, red pulsatile amplitude (7-bit)
- `IR_AC`, 6, IR pulsatile amplitude (7-bit)
- `PW`, 8, log2 of heartbeat period in cycles (period = 2^PW)
- `DC_STEP`, 4, ADC codes removed per `DC_Comp` LSB
- `DARK_LVL`, 16, ambient code with no valid LED (8-bit)
- `SETTLE_CYC`, 4, optical settle time after LED change (>=1)
- `CLK` in 1 system clock
- `rst_n` in 1 reset: one clock; reset is synchronous and active-low
- `LED_DRIVE` in 4 LED current code
- `DC_Comp` in 7 DC compensation code, unsigned
- `LED_RED` in 1 red LED on
- `LED_IR` in 1 IR LED on
- `PGA_Gain` in 4 gain code; gain = `PGA_Gain`+1
- `ADC` out 8 converted sample
- `Settled` out 1 high while tracking a single lit LED

## Operation
- Channel select: RED if `LED_RED`&!`LED_IR`; IR if `LED_IR`&!`LED_RED`; otherwise DARK (both off or both on).
- Phase counter `ph` (PW bits): +1 every cycle, wraps 2^PW-1 -> 0, free-running; shared by both channels.
- tri = ph < 2^(PW-1) ? ph : 2^PW-1-ph; c = tri - 2^(PW-2) (signed, range -2^(PW-2)..2^(PW-2)-1).
- ac = (c * AC_ch) >>> (PW-2) (arithmetic shift, floor).
- Lit channel: v = ((DC_ch*LED_DRIVE)>>3) - DC_Comp*DC_STEP + ((ac*LED_DRIVE)>>>3)*(PGA_Gain+1).
- DARK: v = DARK_LVL - DC_Comp*DC_STEP.
- v computed in 16-bit signed; no overflow possible with legal parameters. Output clamp: v<0 -> 0, v>255 -> 255.
- FSM states DARK, SETTLE, TRACK; `sel_q` = channel select registered each edge.
  - Any state, select = DARK -> DARK.
  - Select lit and != `sel_q` (includes DARK->lit, RED<->IR) -> SETTLE, cnt <= SETTLE_CYC-1.
  - SETTLE, select unchanged: cnt==0 -> TRACK, else cnt-1.
  - TRACK, select unchanged -> TRACK.
  - Change during SETTLE reloads cnt (restart).
- `Settled` = 1 only in TRACK (registered with state).
- `DC_Comp`, `PGA_Gain`, `LED_DRIVE` changes do not trigger settle; they take effect at pipeline latency.

## Timing
- Reset (sync, `rst_n` low at edge): `ADC`=0, `Settled`=0, state DARK, `ph`=0, cnt=0, `sel_q`=DARK, `v_q`=0. Reset beats every other event.
- Stage 1: `v_q` <= v from inputs and `ph` at edge k, loaded every edge.
- Stage 2: `ADC` <= clamp(`v_q`) at edge k+1 if state at that edge is DARK or TRACK; held while SETTLE.
- Steady-state latency: input change at edge k -> `ADC` at edge k+1 output (2 edges).
- LED change sampled at edge k: state SETTLE for SETTLE_CYC cycles, TRACK and `Settled`=1 after edge k+SETTLE_CYC, first new-channel `ADC` after edge k+SETTLE_CYC+1.
- Change to DARK at edge k: `Settled`=0 after edge k; `ADC` shows dark value after edge k+1.

## Test plan
- Reset 3 cycles, LEDs off, `DC_Comp`=0 -> `ADC`=0/`Settled`=0 during reset; `ADC`=16 two edges after release.
- `RED_AC`=0 override, `LED_RED`=1, `LED_DRIVE`=8, `DC_Comp`=0, `PGA_Gain`=0 at edge k -> `ADC` held, `Settled`=1 after k+4, `ADC`=200 after k+5.
- Same, TRACK: `DC_Comp`=20 -> 120; `DC_Comp`=60 -> 0 (clamp); `DC_Comp`=0, `LED_DRIVE`=15 -> 255 (clamp), each two edges after change, `Settled` stays 1.
- Defaults, RED, `LED_DRIVE`=8, `DC_Comp`=18, `PGA_Gain`=15 -> `ADC` triangle min 0 max 240, period exactly 256 cycles.
- RED->IR at k, IR->RED at k+2 -> SETTLE restarts, `Settled`=1 only after k+6; both LEDs on -> `Settled`=0 next edge, `ADC`=16-`DC_Comp`*4 clamped.
- `rst_n` low one edge mid-TRACK -> `ADC`=0, `Settled`=0, `ph`=0 next cycle; resumes DARK or re-settles per LED inputs.

Source files
------------

// File: rtl/ppg_frontend_emulator.sv
// ppg_frontend_emulator: PPG analog front end model (photodiode, DC comp
// DAC, PGA, 8-bit ADC) answering the controller's LED/DC_Comp/PGA drive.
// Ports: CLK, rst_n (sync, active-low), LED_DRIVE[3:0], DC_Comp[6:0],
//        LED_RED, LED_IR, PGA_Gain[3:0] in; ADC[7:0], Settled out.
module ppg_frontend_emulator #(
    parameter logic [7:0] RED_DC     = 8'd200,
    parameter logic [7:0] IR_DC      = 8'd180,
    parameter logic [6:0] RED_AC     = 7'd8,
    parameter logic [6:0] IR_AC      = 7'd6,
    parameter int         PW         = 8,
    parameter int         DC_STEP    = 4,
    parameter logic [7:0] DARK_LVL   = 8'd16,
    parameter int         SETTLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       Settled
);

    localparam int QUARTER = 1 << (PW - 2);
    localparam int CW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        SEL_DARK = 2'd0,
        SEL_RED  = 2'd1,
        SEL_IR   = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        ST_DARK   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2
    } state_e;

    sel_e                sel_w;
    sel_e                sel_q;
    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ph_q;
    logic [PW-1:0]       tri_w;
    logic [7:0]          dc_ch;
    logic [6:0]          ac_ch;
    logic signed [15:0]  c_w, ac_w, dc_w, comp_w, acg_w;
    logic signed [15:0]  v_d, v_q;
    logic [7:0]          adc_d, adc_q;
    logic                settled_q;

    // Channel select: exactly one LED lit selects it, anything else is dark.
    always_comb begin
        sel_w = SEL_DARK;
        if (LED_RED && !LED_IR) begin
            sel_w = SEL_RED;
        end else if (LED_IR && !LED_RED) begin
            sel_w = SEL_IR;
        end
    end

    always_comb begin
        dc_ch = RED_DC;
        ac_ch = RED_AC;
        if (sel_w == SEL_IR) begin
            dc_ch = IR_DC;
            ac_ch = IR_AC;
        end
    end

    // Triangle wave from the phase counter; 2^PW-1-ph is simply ~ph.
    always_comb begin
        tri_w  = ph_q[PW-1] ? ~ph_q : ph_q;
        c_w    = $signed(16'(tri_w)) - $signed(16'(QUARTER));
        ac_w   = (c_w * $signed(16'(ac_ch))) >>> (PW - 2);
        dc_w   = $signed(16'((16'(dc_ch) * 16'(LED_DRIVE)) >> 3));
        comp_w = $signed(16'(16'(DC_Comp) * 16'(DC_STEP)));
        acg_w  = ((ac_w * $signed(16'(LED_DRIVE))) >>> 3)
                 * $signed(16'(PGA_Gain) + 16'd1);
        if (sel_w == SEL_DARK) begin
            v_d = $signed(16'(DARK_LVL)) - comp_w;
        end else begin
            v_d = dc_w - comp_w + acg_w;
        end
    end

    always_comb begin
        if (v_q[15]) begin
            adc_d = 8'd0;
        end else if (|v_q[14:8]) begin
            adc_d = 8'hFF;
        end else begin
            adc_d = v_q[7:0];
        end
    end

    // Next state: a new lit channel (re)starts the settle countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sel_w == SEL_DARK) begin
            state_d = ST_DARK;
        end else if (sel_w != sel_q) begin
            state_d = ST_SETTLE;
            cnt_d   = CW'(SETTLE_CYC - 1);
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_TRACK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= ST_DARK;
            sel_q     <= SEL_DARK;
            cnt_q     <= '0;
            ph_q      <= '0;
            v_q       <= '0;
            adc_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_w;
            cnt_q     <= cnt_d;
            ph_q      <= ph_q + PW'(1);
            v_q       <= v_d;
            settled_q <= (state_d == ST_TRACK);
            // ADC freezes while the optics settle.
            if (state_q != ST_SETTLE) begin
                adc_q <= adc_d;
            end
        end
    end

    assign ADC     = adc_q;
    assign Settled = settled_q;

endmodule

// File: tb/tb_ppg_frontend_emulator.sv
// tb_ppg_frontend_emulator: known-answer and randomized checks of the
// PPG front end against a cycle-level behavioural model.
module tb_ppg_frontend_emulator;

    localparam int S = 4;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] LED_DRIVE = 4'd8;
    logic [6:0] DC_Comp = 7'd0;
    logic       LED_RED = 1'b0;
    logic       LED_IR = 1'b0;
    logic [3:0] PGA_Gain = 4'd0;
    logic [7:0] adc_a, adc_b;
    logic       set_a, set_b;

    int errors = 0;
    int checks = 0;

    int m_vq[2];
    int m_adc[2];
    int m_run;
    int m_prevsel;
    int m_ph;
    bit m_settled;

    always #5 CLK = ~CLK;

    ppg_frontend_emulator dut_a (
        .CLK(CLK), .rst_n(rst_n), .LED_DRIVE(LED_DRIVE),
        .DC_Comp(DC_Comp), .LED_RED(LED_RED), .LED_IR(LED_IR),
        .PGA_Gain(PGA_Gain), .ADC(adc_a), .Settled(set_a)
    );

    ppg_frontend_emulator #(.RED_AC(7'd0)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .LED_DRIVE(LED_DRIVE),
        .DC_Comp(DC_Comp), .LED_RED(LED_RED), .LED_IR(LED_IR),
        .PGA_Gain(PGA_Gain), .ADC(adc_b), .Settled(set_b)
    );

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clampv(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int cur_sel();
        if (LED_RED && !LED_IR) return 1;
        if (LED_IR && !LED_RED) return 2;
        return 0;
    endfunction

    // Sample value from the front-end equations, plain integer math.
    function automatic int model_v(int sel, int red_amp, int ph);
        int comp, dc, amp, tr, c, ac, drv;
        drv  = int'(LED_DRIVE);
        comp = int'(DC_Comp) * 4;
        if (sel == 0) return 16 - comp;
        dc  = (sel == 1) ? 200 : 180;
        amp = (sel == 1) ? red_amp : 6;
        tr  = (ph < 128) ? ph : 255 - ph;
        c   = tr - 64;
        ac  = fdiv(c * amp, 64);
        return (dc * drv) / 8 - comp
               + fdiv(ac * drv, 8) * (int'(PGA_Gain) + 1);
    endfunction

    // Settling is tracked as "edges the same lit channel has been held".
    task automatic model_edge();
        int  s;
        bit  holding;
        int  amp[2];
        amp[0] = 8;
        amp[1] = 0;
        if (!rst_n) begin
            m_vq[0] = 0; m_vq[1] = 0;
            m_adc[0] = 0; m_adc[1] = 0;
            m_run = 0; m_prevsel = 0; m_ph = 0;
            m_settled = 0;
        end else begin
            s = cur_sel();
            holding = (m_prevsel != 0) && (m_run <= S);
            for (int i = 0; i < 2; i++) begin
                if (!holding) m_adc[i] = clampv(m_vq[i]);
                m_vq[i] = model_v(s, amp[i], m_ph);
            end
            m_run = (s == m_prevsel) ? m_run + 1 : 1;
            m_prevsel = s;
            m_settled = (s != 0) && (m_run >= S + 1);
            m_ph = (m_ph + 1) % 256;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        LED_RED = 1'b0; LED_IR = 1'b0;
        DC_Comp = 7'd0; LED_DRIVE = 4'd8; PGA_Gain = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (adc_a !== 8'd0 || set_a !== 1'b0) begin
                $display("FAIL reset_hold: adc=%0d set=%0b want 0/0",
                         adc_a, set_a);
                errors++;
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (adc_a !== 8'd0) begin
            $display("FAIL reset_rel1: adc=%0d want 0", adc_a);
            errors++;
        end
        tick();
        checks++;
        if (adc_a !== 8'd16 || adc_b !== 8'd16) begin
            $display("FAIL reset_dark: adc=%0d/%0d want 16", adc_a, adc_b);
            errors++;
        end
    endtask

    task automatic test_settle_ac0();
        LED_RED = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (set_b !== 1'b0 || adc_b !== 8'd16) begin
                $display("FAIL settle_wait%0d: set=%0b adc=%0d want 0/16",
                         i, set_b, adc_b);
                errors++;
            end
        end
        tick();
        checks++;
        if (set_b !== 1'b1 || adc_b !== 8'd16) begin
            $display("FAIL settle_k4: set=%0b adc=%0d want 1/16",
                     set_b, adc_b);
            errors++;
        end
        tick();
        checks++;
        if (adc_b !== 8'd200 || set_b !== 1'b1) begin
            $display("FAIL settle_k5: adc=%0d set=%0b want 200/1",
                     adc_b, set_b);
            errors++;
        end
        checks++;
        if (int'(adc_a) !== m_adc[0]) begin
            $display("FAIL settle_model: adc=%0d want %0d",
                     adc_a, m_adc[0]);
            errors++;
        end
    endtask

    task automatic test_comp_clamp();
        int tc[3], td[3], te[3];
        int prev;
        tc[0] = 20; td[0] = 8;  te[0] = 120;
        tc[1] = 60; td[1] = 8;  te[1] = 0;
        tc[2] = 0;  td[2] = 15; te[2] = 255;
        prev = 200;
        for (int i = 0; i < 3; i++) begin
            DC_Comp = 7'(tc[i]);
            LED_DRIVE = 4'(td[i]);
            tick();
            checks++;
            if (int'(adc_b) !== prev) begin
                $display("FAIL clamp_lat%0d: adc=%0d want %0d",
                         i, adc_b, prev);
                errors++;
            end
            tick();
            checks++;
            if (int'(adc_b) !== te[i] || set_b !== 1'b1) begin
                $display("FAIL clamp%0d: adc=%0d set=%0b want %0d/1",
                         i, adc_b, set_b, te[i]);
                errors++;
            end
            prev = te[i];
        end
    endtask

    task automatic test_triangle();
        logic [7:0] samp[512];
        int mn, mx, bad256, diff128;
        DC_Comp = 7'd18; LED_DRIVE = 4'd8; PGA_Gain = 4'd15;
        tick();
        tick();
        mn = 999; mx = -1;
        for (int t = 0; t < 512; t++) begin
            tick();
            samp[t] = adc_a;
            if (int'(adc_a) < mn) mn = int'(adc_a);
            if (int'(adc_a) > mx) mx = int'(adc_a);
            checks++;
            if (int'(adc_a) !== m_adc[0]) begin
                $display("FAIL tri_t%0d: adc=%0d want %0d",
                         t, adc_a, m_adc[0]);
                errors++;
            end
        end
        checks++;
        if (mn != 0 || mx != 240) begin
            $display("FAIL tri_range: min=%0d max=%0d want 0/240", mn, mx);
            errors++;
        end
        bad256 = 0; diff128 = 0;
        for (int t = 0; t < 256; t++) begin
            if (samp[t] != samp[t+256]) bad256++;
            if (samp[t] != samp[t+128]) diff128++;
        end
        checks++;
        if (bad256 != 0 || diff128 == 0) begin
            $display("FAIL tri_period: p256_diffs=%0d p128_diffs=%0d want 0/>0",
                     bad256, diff128);
            errors++;
        end
    endtask

    task automatic test_led_switch();
        int want;
        DC_Comp = 7'd2; PGA_Gain = 4'd0;
        LED_RED = 1'b0; LED_IR = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            if (e == 2) begin
                LED_RED = 1'b1; LED_IR = 1'b0;
            end
            tick();
            want = (e == 6) ? 1 : 0;
            checks++;
            if (int'(set_a) !== want || set_a !== m_settled) begin
                $display("FAIL switch_k%0d: set=%0b want %0d", e, set_a, want);
                errors++;
            end
        end
        LED_IR = 1'b1;
        tick();
        checks++;
        if (set_a !== 1'b0) begin
            $display("FAIL both_set: set=%0b want 0", set_a);
            errors++;
        end
        tick();
        checks++;
        if (adc_a !== 8'd8 || adc_b !== 8'd8) begin
            $display("FAIL both_adc: adc=%0d/%0d want 8", adc_a, adc_b);
            errors++;
        end
        DC_Comp = 7'd18;
        tick();
        tick();
        checks++;
        if (adc_a !== 8'd0) begin
            $display("FAIL both_clamp: adc=%0d want 0", adc_a);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        LED_RED = 1'b1; LED_IR = 1'b0; DC_Comp = 7'd0; PGA_Gain = 4'd3;
        n = 0;
        while (set_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (set_a !== 1'b1) begin
            $display("FAIL mid_track: set=%0b want 1 within 20", set_a);
            errors++;
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (adc_a !== 8'd0 || set_a !== 1'b0) begin
            $display("FAIL mid_rst: adc=%0d set=%0b want 0/0", adc_a, set_a);
            errors++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (int'(adc_a) !== m_adc[0] || set_a !== m_settled) begin
                $display("FAIL mid_resume%0d: adc=%0d set=%0b want %0d/%0b",
                         i, adc_a, set_a, m_adc[0], m_settled);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                LED_RED = 1'($urandom);
                LED_IR = 1'($urandom);
            end
            if ($urandom_range(3) == 0) LED_DRIVE = 4'($urandom);
            if ($urandom_range(3) == 0) DC_Comp = 7'($urandom_range(80));
            if ($urandom_range(3) == 0) PGA_Gain = 4'($urandom);
            rst_n = ($urandom_range(150) != 0);
            tick();
            checks++;
            if (int'(adc_a) !== m_adc[0] || int'(adc_b) !== m_adc[1]
                || set_a !== m_settled || set_b !== m_settled) begin
                $display("FAIL rand%0d: adc=%0d/%0d set=%0b/%0b want %0d/%0d/%0b",
                         i, adc_a, adc_b, set_a, set_b,
                         m_adc[0], m_adc[1], m_settled);
                errors++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_settle_ac0();
        test_comp_clamp();
        test_triangle();
        test_led_switch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
